// File: rtl/muldiv_unit_if.sv
// Handshake/result bundle between the EXE stage and the multiply/divide unit.
// The master side is the pipeline; the slave side is muldiv_unit.
interface muldiv_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        busy_o;
  logic        hilowe_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, flush_i,
    input  busy_o, hilowe_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, flush_i,
    output busy_o, hilowe_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO pair: stalls EXE while
// working, then pulses hilowe_o for one cycle with the 64-bit result in hi_o/lo_o.
module muldiv_unit #(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst,
  muldiv_unit_if.slave  md
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Control / architectural result state (reset)
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  // Working operands (no reset; only meaningful after a latch in IDLE)
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;

  logic                busy;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic              is_signed);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    if (is_signed && sv < 0) return DATA_W'(-sv);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] set_sign(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    if (neg) return DATA_W'(-sv);
    return v;
  endfunction

  // Multiply: sign- or zero-extend to 64 bits so one signed multiply covers both forms
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod_w;
  assign a_ext  = signed'({{DATA_W{sgn_q & src1_q[DATA_W-1]}}, src1_q});
  assign b_ext  = signed'({{DATA_W{sgn_q & src2_q[DATA_W-1]}}, src2_q});
  assign prod_w = a_ext * b_ext;

  // Divide: one restoring step on magnitudes; quo_q shifts the dividend out as quotient bits enter
  logic [DATA_W-1:0] dvs_w;
  logic [DATA_W:0]   shift_w, trial_w;
  logic [DATA_W-1:0] rem_n, quo_n;
  logic              quo_neg, rem_neg;

  assign dvs_w   = mag(src2_q, sgn_q);
  assign shift_w = {rem_q, quo_q[DATA_W-1]};
  assign trial_w = shift_w - {1'b0, dvs_w};
  assign quo_neg = sgn_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
  assign rem_neg = sgn_q & src1_q[DATA_W-1];

  always_comb begin
    rem_n = shift_w[DATA_W-1:0];
    quo_n = {quo_q[DATA_W-2:0], 1'b0};
    if (!trial_w[DATA_W]) begin
      rem_n = trial_w[DATA_W-1:0];
      quo_n = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    busy    = 1'b0;

    if (md.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md.start_i) begin
            busy   = 1'b1;
            sgn_d  = ~md.op_i[0];
            src1_d = md.src1_i;
            src2_d = md.src2_i;
            rem_d  = '0;
            quo_d  = mag(md.src1_i, ~md.op_i[0]);
            cnt_d  = '0;
            if (!md.op_i[1]) begin
              state_d = MUL;
            end else if (md.src2_i == '0) begin
              state_d = DONE;
              hi_d    = md.src1_i;
              lo_d    = '1;
            end else begin
              state_d = DIV;
            end
          end
        end
        MUL: begin
          busy  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            hi_d    = prod_w[2*DATA_W-1:DATA_W];
            lo_d    = prod_w[DATA_W-1:0];
          end
        end
        DIV: begin
          busy  = 1'b1;
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            hi_d    = set_sign(rem_n, rem_neg);
            lo_d    = set_sign(quo_n, quo_neg);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control and result registers
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand / iteration registers
  always_ff @(posedge cpu_clk_50M) begin
    sgn_q  <= sgn_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
  end

  assign md.busy_o   = busy & ~cpu_rst;
  assign md.hilowe_o = (state_q == DONE) & ~md.flush_i;
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared every cycle against a transaction-level arithmetic model.
module tb_muldiv_unit;

  localparam int MUL_STAGES = 2;
  localparam int DIV_ITERS  = 32;

  logic clk;
  logic rst;
  muldiv_unit_if bus();

  muldiv_unit #(
    .MUL_STAGES (MUL_STAGES),
    .DIV_ITERS  (DIV_ITERS)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .md          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          busy_seen;
  logic        exp_busy;
  logic        exp_hilowe;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  // Expected {hi, lo} straight from the instruction definitions
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    q  = 0;
    r  = 0;
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return 64'(ua * ub);
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Cycle index (from the start cycle) at which the write strobe appears
  function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_STAGES + 1;
    if (b == 32'd0) return 1;
    return DIV_ITERS + 1;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    cmp("busy_o",   64'(bus.busy_o),   64'(exp_busy));
    cmp("hilowe_o", 64'(bus.hilowe_o), 64'(exp_hilowe));
    cmp("hi_o",     64'(bus.hi_o),     64'(cur_hi));
    cmp("lo_o",     64'(bus.lo_o),     64'(cur_lo));
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, return just after next edge
  task automatic cycle(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic eb, input logic eh);
    bus.start_i = st;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.flush_i = fl;
    exp_busy    = eb;
    exp_hilowe  = eh;
    @(negedge clk);
    if (bus.busy_o) busy_seen++;
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // One instruction held in EXE; operands are scrambled once the unit has latched them
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    logic [63:0] r;
    int          lat;
    logic        fl;
    r         = model(op, a, b);
    lat       = lat_of(op, b);
    busy_seen = 0;
    for (int c = 0; c <= lat; c++) begin
      fl = (c == flush_at);
      if (c == lat) begin
        cur_hi = r[63:32];
        cur_lo = r[31:0];
      end
      if (c == 0) cycle(1'b1, op, a, b, fl, !fl, 1'b0);
      else        cycle(1'b1, 2'($urandom), $urandom, $urandom, fl, (c < lat) && !fl, (c == lat) && !fl);
      if (fl) begin
        idle(1);
        break;
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          fa;
    n_vec       = 0;
    n_err       = 0;
    busy_seen   = 0;
    cur_hi      = '0;
    cur_lo      = '0;
    exp_busy    = 1'b0;
    exp_hilowe  = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.flush_i = 1'b0;
    rst         = 1'b1;

    // Reset state
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Pin the model against hand-computed results
    cmp("model_mult",   model(2'b00, 32'hFFFF_FFFE, 32'd3),         64'hFFFF_FFFF_FFFF_FFFA);
    cmp("model_multu",  model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    cmp("model_div",    model(2'b10, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
    cmp("model_divu0",  model(2'b11, 32'd100, 32'd0),               64'h0000_0064_FFFF_FFFF);
    cmp("model_divovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    cmp("lat_div",      64'(lat_of(2'b10, 32'd2)),                  64'd33);

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, -1);
    cmp("mult_busy_cycles", 64'(busy_seen), 64'd3);
    cmp("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
    cmp("mult_lo", 64'(bus.lo_o), 64'hFFFF_FFFA);
    idle(1);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    cmp("multu_busy_cycles", 64'(busy_seen), 64'd3);
    cmp("multu_hi", 64'(bus.hi_o), 64'hFFFF_FFFE);
    cmp("multu_lo", 64'(bus.lo_o), 64'h0000_0001);
    idle(1);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    cmp("div_busy_cycles", 64'(busy_seen), 64'd33);
    cmp("div_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
    cmp("div_lo", 64'(bus.lo_o), 64'hFFFF_FFFD);
    idle(1);

    run_op(2'b11, 32'd100, 32'd0, -1);
    cmp("divu0_busy_cycles", 64'(busy_seen), 64'd1);
    cmp("divu0_hi", 64'(bus.hi_o), 64'd100);
    cmp("divu0_lo", 64'(bus.lo_o), 64'hFFFF_FFFF);
    idle(1);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    cmp("divovf_hi", 64'(bus.hi_o), 64'h0);
    cmp("divovf_lo", 64'(bus.lo_o), 64'h8000_0000);
    idle(1);

    // Flush mid-divide: no strobe, previous result retained
    run_op(2'b10, 32'd1000, 32'd3, 10);
    cmp("flush_hi_kept", 64'(bus.hi_o), 64'h0);
    cmp("flush_lo_kept", 64'(bus.lo_o), 64'h8000_0000);
    idle(1);

    // Asynchronous reset in the middle of a divide
    for (int c = 0; c < 5; c++) begin
      if (c == 0) cycle(1'b1, 2'b10, 32'd12345, 32'd17, 1'b0, 1'b1, 1'b0);
      else        cycle(1'b1, 2'($urandom), $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    end
    #1;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    cur_hi      = '0;
    cur_lo      = '0;
    exp_busy    = 1'b0;
    exp_hilowe  = 1'b0;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Back-to-back MULT then DIVU
    run_op(2'b00, 32'd7, 32'hFFFF_FFFB, -1);
    run_op(2'b11, 32'd1000, 32'd7, -1);
    cmp("b2b_hi", 64'(bus.hi_o), 64'd6);
    cmp("b2b_lo", 64'(bus.lo_o), 64'd142);
    idle(1);

    // Randomized operations, occasional flush at any cycle including the strobe cycle
    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      fa  = -1;
      if ($urandom_range(0, 5) == 0) fa = int'($urandom_range(0, lat_of(rop, rb)));
      run_op(rop, ra, rb, fa);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
